// File: rtl/fp_op_sequencer.sv
// rtl/fp_op_sequencer.sv - FP op sequencer: issue capture, FPU launch, writeback, sticky fflags (optional watchdog: FPSEQ_TIMEOUT_EN)
module fp_op_sequencer #(
    parameter int DATA_W         = 32,
    parameter int OP_W           = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_issue_valid,
    output logic              out_issue_ready,
    input  logic [OP_W-1:0]   in_fp_op,
    input  logic [DATA_W-1:0] in_src_a,
    input  logic [DATA_W-1:0] in_src_b,
    input  logic [4:0]        in_rd,
    input  logic              in_dest_int,
    input  logic              in_flush,
    output logic              out_stall,
    output logic              out_fpu_start,
    output logic [OP_W-1:0]   out_fpu_op,
    output logic [DATA_W-1:0] out_fpu_a,
    output logic [DATA_W-1:0] out_fpu_b,
    input  logic              in_fpu_done,
    input  logic [DATA_W-1:0] in_fpu_result,
    input  logic [4:0]        in_fpu_flags,
    output logic              out_wb_valid,
    input  logic              in_wb_ready,
    output logic [4:0]        out_wb_rd,
    output logic              out_wb_int,
    output logic [DATA_W-1:0] out_wb_data,
    input  logic              in_fflags_clr,
    output logic [4:0]        out_fflags,
    output logic              out_timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_WB     = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t state, next_state;

    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [4:0]        rd_q;
    logic              int_q;
    logic [DATA_W-1:0] res_q;
    logic [4:0]        flags_q;
    logic [4:0]        fflags_q;

    logic capture;
    logic latch_res;
    logic commit;
    logic start;

`ifdef FPSEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    logic             cnt_expired;
    logic             fire_timeout;

    assign cnt_expired = (cnt_q == CNT_MAX);

    // Watchdog counter: cleared at launch, counts WAIT/DRAIN cycles, saturates at the limit
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_LAUNCH) begin
                cnt_q <= '0;
            end else if ((state == S_WAIT || state == S_DRAIN) && !cnt_expired) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (fire_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign out_timeout = timeout_q;
`else
    // Watchdog compiled out; a zero or negative limit is the only way this reads high
    assign out_timeout = (TIMEOUT_CYCLES < 1);
`endif

    // State register
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control strobes; flush always has priority over progress
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        latch_res  = 1'b0;
        commit     = 1'b0;
        start      = 1'b0;
`ifdef FPSEQ_TIMEOUT_EN
        fire_timeout = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (in_issue_valid && !in_flush) begin
                    capture    = 1'b1;
                    next_state = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (in_flush) begin
                    next_state = S_IDLE;
                end else begin
                    start      = 1'b1;
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (in_flush) begin
                    next_state = S_DRAIN;
                end else if (in_fpu_done) begin
                    latch_res  = 1'b1;
                    next_state = S_WB;
                end
`ifdef FPSEQ_TIMEOUT_EN
                else if (cnt_expired) begin
                    fire_timeout = 1'b1;
                    next_state   = S_IDLE;
                end
`endif
            end
            S_WB: begin
                if (in_flush) begin
                    next_state = S_IDLE;
                end else if (in_wb_ready) begin
                    commit     = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (in_fpu_done) begin
                    next_state = S_IDLE;
                end
`ifdef FPSEQ_TIMEOUT_EN
                else if (cnt_expired) begin
                    fire_timeout = 1'b1;
                    next_state   = S_IDLE;
                end
`endif
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture at issue and result/flag latch on FPU completion
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            int_q   <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            if (capture) begin
                op_q  <= in_fp_op;
                a_q   <= in_src_a;
                b_q   <= in_src_b;
                rd_q  <= in_rd;
                int_q <= in_dest_int;
            end
            if (latch_res) begin
                res_q   <= in_fpu_result;
                flags_q <= in_fpu_flags;
            end
        end
    end

    // Sticky exception flags; a same-cycle clear is applied before the committing op's flags
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            fflags_q <= '0;
        end else if (commit) begin
            fflags_q <= (in_fflags_clr ? 5'b0 : fflags_q) | flags_q;
        end else if (in_fflags_clr) begin
            fflags_q <= '0;
        end
    end

    assign out_issue_ready = (state == S_IDLE);
    assign out_stall       = (state != S_IDLE);
    assign out_fpu_start   = start;
    assign out_fpu_op      = op_q;
    assign out_fpu_a       = a_q;
    assign out_fpu_b       = b_q;
    assign out_wb_valid    = (state == S_WB);
    assign out_wb_rd       = rd_q;
    assign out_wb_int      = int_q;
    assign out_wb_data     = res_q;
    assign out_fflags      = fflags_q;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// tb/tb_fp_op_sequencer.sv - directed self-checking bench for fp_op_sequencer
module tb_fp_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready;
    logic [4:0]  fp_op;
    logic [31:0] src_a, src_b;
    logic [4:0]  rd;
    logic        dest_int, flush, stall, fpu_start;
    logic [4:0]  fpu_op;
    logic [31:0] fpu_a, fpu_b;
    logic        fpu_done;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_flags;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic        wb_int;
    logic [31:0] wb_data;
    logic        fflags_clr;
    logic [4:0]  fflags;
    logic        timeout;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fp_op_sequencer #(.DATA_W(32), .OP_W(5), .TIMEOUT_CYCLES(64)) dut (
        .in_clk(clk), .in_rst(rst),
        .in_issue_valid(issue_valid), .out_issue_ready(issue_ready),
        .in_fp_op(fp_op), .in_src_a(src_a), .in_src_b(src_b),
        .in_rd(rd), .in_dest_int(dest_int), .in_flush(flush),
        .out_stall(stall), .out_fpu_start(fpu_start),
        .out_fpu_op(fpu_op), .out_fpu_a(fpu_a), .out_fpu_b(fpu_b),
        .in_fpu_done(fpu_done), .in_fpu_result(fpu_result), .in_fpu_flags(fpu_flags),
        .out_wb_valid(wb_valid), .in_wb_ready(wb_ready),
        .out_wb_rd(wb_rd), .out_wb_int(wb_int), .out_wb_data(wb_data),
        .in_fflags_clr(fflags_clr), .out_fflags(fflags), .out_timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single cycle; returns in the LAUNCH cycle
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic di);
        issue_valid = 1'b1;
        fp_op = op; src_a = a; src_b = b; rd = r; dest_int = di;
        tick();
        issue_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 0; fp_op = 0; src_a = 0; src_b = 0; rd = 0; dest_int = 0;
        flush = 0; fpu_done = 0; fpu_result = 0; fpu_flags = 0; wb_ready = 0; fflags_clr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_start", fpu_start, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_fflags", fflags, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_fpu_a", fpu_a, 0);

        // FMUL minimum latency: 3.0 * 2.0 = 6.0
        chk("t1_ready_T", issue_ready, 1);
        issue(5'd2, 32'h4040_0000, 32'h4000_0000, 5'd5, 1'b0);
        chk("t1_start_T1", fpu_start, 1);
        chk("t1_stall_T1", stall, 1);
        chk("t1_fpu_op", fpu_op, 5'd2);
        chk("t1_fpu_a", fpu_a, 32'h4040_0000);
        chk("t1_fpu_b", fpu_b, 32'h4000_0000);
        tick();
        chk("t1_start_T2", fpu_start, 0);
        chk("t1_stall_T2", stall, 1);
        chk("t1_fpu_a_wait", fpu_a, 32'h4040_0000);
        fpu_done = 1; fpu_result = 32'h40C0_0000; fpu_flags = 5'b0; wb_ready = 1;
        tick();
        fpu_done = 0;
        chk("t1_wb_valid_T3", wb_valid, 1);
        chk("t1_wb_rd", wb_rd, 5'd5);
        chk("t1_wb_data", wb_data, 32'h40C0_0000);
        chk("t1_wb_int", wb_int, 0);
        chk("t1_stall_T3", stall, 1);
        tick();
        chk("t1_wb_valid_T4", wb_valid, 0);
        chk("t1_stall_T4", stall, 0);
        chk("t1_fflags", fflags, 0);
        wb_ready = 0;

        // FDIV, 10-cycle FPU, regfile back-pressure for 3 cycles
        issue(5'd3, 32'h3F80_0000, 32'h4000_0000, 5'd9, 1'b0);
        chk("t2_start", fpu_start, 1);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("t2_wait_ready", issue_ready, 0);
            chk("t2_wait_wb_valid", wb_valid, 0);
            chk("t2_wait_start", fpu_start, 0);
        end
        fpu_done = 1; fpu_result = 32'h3F00_0000; fpu_flags = 5'b00001;
        tick();
        fpu_done = 0; fpu_result = 32'hDEAD_BEEF; fpu_flags = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            chk("t2_wb_valid_held", wb_valid, 1);
            chk("t2_wb_data_held", wb_data, 32'h3F00_0000);
            chk("t2_wb_rd_held", wb_rd, 5'd9);
            chk("t2_ready_low", issue_ready, 0);
            tick();
        end
        wb_ready = 1;
        chk("t2_wb_valid_hs", wb_valid, 1);
        tick();
        wb_ready = 0;
        chk("t2_fflags", fflags, 5'b00001);
        chk("t2_idle", issue_ready, 1);

        // Flush two cycles into WAIT, FPU finishes four cycles later with NV
        issue(5'd0, 32'h1, 32'h2, 5'd3, 1'b0);
        tick();
        tick();
        flush = 1;
        tick();
        flush = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_drain_stall", stall, 1);
            chk("t3_drain_wb_valid", wb_valid, 0);
            tick();
        end
        fpu_done = 1; fpu_flags = 5'b10000; fpu_result = 32'h1234_5678;
        chk("t3_drain_stall_done", stall, 1);
        tick();
        fpu_done = 0;
        chk("t3_idle_after_done", issue_ready, 1);
        chk("t3_wb_valid", wb_valid, 0);
        chk("t3_fflags_kept", fflags, 5'b00001);

        // Flush in IDLE blocks the issue
        issue_valid = 1; flush = 1;
        tick();
        issue_valid = 0; flush = 0;
        chk("t4_idle_flush_stall", stall, 0);
        chk("t4_idle_flush_start", fpu_start, 0);

        // Flush in LAUNCH suppresses the start pulse
        issue(5'd1, 32'h5, 32'h6, 5'd4, 1'b1);
        flush = 1;
        #1;
        chk("t4_launch_flush_start", fpu_start, 0);
        tick();
        flush = 0;
        chk("t4_launch_flush_idle", issue_ready, 1);
        chk("t4_launch_flush_start_after", fpu_start, 0);

        // Flush and wb_ready together in WB: nothing commits
        issue(5'd1, 32'h5, 32'h6, 5'd4, 1'b1);
        tick();
        fpu_done = 1; fpu_result = 32'h77; fpu_flags = 5'b00100;
        tick();
        fpu_done = 0;
        chk("t4_wb_int", wb_int, 1);
        flush = 1; wb_ready = 1;
        tick();
        flush = 0; wb_ready = 0;
        chk("t4_wb_flush_valid", wb_valid, 0);
        chk("t4_wb_flush_fflags", fflags, 5'b00001);
        chk("t4_wb_flush_idle", issue_ready, 1);

        // Done while flushed in WAIT still drains; then a fresh done returns to IDLE
        issue(5'd4, 32'h8, 32'h9, 5'd7, 1'b0);
        tick();
        flush = 1; fpu_done = 1; fpu_flags = 5'b01000;
        tick();
        flush = 0; fpu_done = 0;
        chk("t4_flush_done_drain", stall, 1);
        chk("t4_flush_done_wb", wb_valid, 0);
        fpu_done = 1;
        tick();
        fpu_done = 0;
        chk("t4_flush_done_idle", stall, 0);
        chk("t4_flush_done_fflags", fflags, 5'b00001);

        // Done during LAUNCH ignored; clear coincides with WB handshake
        issue(5'd5, 32'hA, 32'hB, 5'd8, 1'b0);
        fpu_done = 1; fpu_result = 32'hBAD0_0000; fpu_flags = 5'b00010;
        tick();
        fpu_done = 0;
        chk("t5_launch_done_ignored", wb_valid, 0);
        chk("t5_in_wait", stall, 1);
        fpu_done = 1; fpu_result = 32'h4000_0000; fpu_flags = 5'b10000;
        tick();
        fpu_done = 0;
        chk("t5_wb_data", wb_data, 32'h4000_0000);
        wb_ready = 1; fflags_clr = 1;
        tick();
        wb_ready = 0; fflags_clr = 0;
        chk("t5_fflags_clr_commit", fflags, 5'b10000);

        // Default build: no watchdog, stall held while the FPU never finishes
        issue(5'd6, 32'h1, 32'h1, 5'd1, 1'b0);
        repeat (80) tick();
        chk("t6_stall_held", stall, 1);
        chk("t6_no_timeout", timeout, 0);
        chk("t6_no_wb", wb_valid, 0);

        // Asynchronous reset mid-op
        #2 rst = 1'b1;
        #1;
        chk("t7_async_rst_stall", stall, 0);
        chk("t7_async_rst_ready", issue_ready, 1);
        chk("t7_async_rst_fflags", fflags, 0);
        chk("t7_async_rst_fpu_a", fpu_a, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
